// File: rtl/sau_4o_serial.sv
// Serial 4-input odd-part butterfly of the 8-point DCT-2: accumulates o[0..3]
// against the 89/75/50/18 matrix with shift-add products, then rounds and saturates.
module sau_4o_serial #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic [3:0]              in_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y3,
  output logic signed [OUT_W-1:0] y5,
  output logic signed [OUT_W-1:0] y7
);

  localparam int ACC_W = IN_W + 9;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RND = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t                   r_state;
  logic [1:0]               r_cnt;
  logic [3:0]               r_shift;
  logic signed [ACC_W-1:0]  r_acc [4];
  logic signed [OUT_W-1:0]  r_y   [4];
  logic                     r_out_valid;

  logic signed [ACC_W-1:0]  w_x, w_x9, w_x25, w_x18, w_x50, w_x75, w_x89;
  logic signed [ACC_W-1:0]  w_term [4];
  logic                     w_accept;

  // One extra bit of headroom so the rounding bias can never wrap.
  function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] acc,
                                                     input logic [3:0] s);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] b;
    b    = '0;
    b[0] = 1'b1;
    t    = {acc[ACC_W-1], acc};
    if (s != 4'd0) begin
      b = b << (s - 4'd1);
      t = (t + b) >>> s;
    end
    if (t > SAT_MAX)      t = SAT_MAX;
    else if (t < SAT_MIN) t = SAT_MIN;
    return t[OUT_W-1:0];
  endfunction

  assign w_x   = ACC_W'(in_data);
  assign w_x9  = w_x + (w_x <<< 3);
  assign w_x25 = w_x9 + (w_x <<< 4);
  assign w_x18 = w_x9 <<< 1;
  assign w_x50 = w_x25 <<< 1;
  assign w_x75 = (w_x25 <<< 2) - w_x25;
  assign w_x89 = w_x25 + (w_x <<< 6);

  // Column k of the symmetric odd matrix, selected by the sample index.
  always_comb begin
    w_term[0] = w_x89;
    w_term[1] = w_x75;
    w_term[2] = w_x50;
    w_term[3] = w_x18;
    case (r_cnt)
      2'd1: begin
        w_term[0] = w_x75;
        w_term[1] = -w_x18;
        w_term[2] = -w_x89;
        w_term[3] = -w_x50;
      end
      2'd2: begin
        w_term[0] = w_x50;
        w_term[1] = -w_x89;
        w_term[2] = w_x18;
        w_term[3] = w_x75;
      end
      2'd3: begin
        w_term[0] = w_x18;
        w_term[1] = -w_x50;
        w_term[2] = w_x75;
        w_term[3] = -w_x89;
      end
      default: ;
    endcase
  end

  assign in_ready  = (r_state == ACC) && !clr;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign y1        = r_y[0];
  assign y3        = r_y[1];
  assign y5        = r_y[2];
  assign y7        = r_y[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_cnt       <= 2'd0;
      r_shift     <= 4'd0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_acc[i] <= '0;
        r_y[i]   <= '0;
      end
    end else if (clr) begin
      r_state     <= ACC;
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            for (int i = 0; i < 4; i++) begin
              if (r_cnt == 2'd0) r_acc[i] <= w_term[i];
              else               r_acc[i] <= r_acc[i] + w_term[i];
            end
            if (r_cnt == 2'd0) r_shift <= in_shift;
            if (r_cnt == 2'd3) begin
              r_cnt   <= 2'd0;
              r_state <= RND;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        RND: begin
          for (int i = 0; i < 4; i++) r_y[i] <= rnd_sat(r_acc[i], r_shift);
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACC;
          end
        end
        default: begin
          r_state     <= ACC;
          r_cnt       <= 2'd0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sau_4o_serial.sv
// Scoreboard bench for sau_4o_serial: a default-width and a 16-bit-output
// instance share stimulus; a monitor checks every presented result.
module tb_sau_4o_serial;

  localparam int IN_W = 19;
  localparam int OWA  = 27;
  localparam int OWB  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic signed [IN_W-1:0] in_data = '0;
  logic [3:0] in_shift = 4'd0;
  logic out_ready = 1'b1;
  logic rdy_rand = 1'b0;

  logic ra, rb, va, vb;
  logic signed [OWA-1:0] ya1, ya3, ya5, ya7;
  logic signed [OWB-1:0] yb1, yb3, yb5, yb7;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    longint a1, a3, a5, a7, b1, b3, b5, b7;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  sau_4o_serial #(.IN_W(IN_W), .OUT_W(OWA)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ra),
    .in_data(in_data), .in_shift(in_shift), .out_valid(va), .out_ready(out_ready),
    .y1(ya1), .y3(ya3), .y5(ya5), .y7(ya7));

  sau_4o_serial #(.IN_W(IN_W), .OUT_W(OWB)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rb),
    .in_data(in_data), .in_shift(in_shift), .out_valid(vb), .out_ready(out_ready),
    .y1(yb1), .y3(yb3), .y5(yb5), .y7(yb7));

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: matrix product with plain integers, then round and clamp.
  function automatic longint rs(input longint acc, input int s, input int ow);
    longint t, mx, mn;
    t = acc;
    if (s > 0) t = (acc + (longint'(1) << (s - 1))) >>> s;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    if (t > mx) t = mx;
    if (t < mn) t = mn;
    return t;
  endfunction

  function automatic exp_t model(input longint o0, input longint o1, input longint o2,
                                 input longint o3, input int s);
    exp_t e;
    longint p1, p3, p5, p7;
    p1 = 89*o0 + 75*o1 + 50*o2 + 18*o3;
    p3 = 75*o0 - 18*o1 - 89*o2 - 50*o3;
    p5 = 50*o0 - 89*o1 + 18*o2 + 75*o3;
    p7 = 18*o0 - 50*o1 + 75*o2 - 89*o3;
    e.a1 = rs(p1, s, OWA); e.a3 = rs(p3, s, OWA);
    e.a5 = rs(p5, s, OWA); e.a7 = rs(p7, s, OWA);
    e.b1 = rs(p1, s, OWB); e.b3 = rs(p3, s, OWB);
    e.b5 = rs(p5, s, OWB); e.b7 = rs(p7, s, OWB);
    return e;
  endfunction

  function automatic exp_t mk(input longint a1, input longint a3, input longint a5,
                              input longint a7, input longint b1, input longint b3,
                              input longint b5, input longint b7);
    exp_t e;
    e.a1 = a1; e.a3 = a3; e.a5 = a5; e.a7 = a7;
    e.b1 = b1; e.b3 = b3; e.b5 = b5; e.b7 = b7;
    return e;
  endfunction

  task automatic send(input int d, input int s);
    bit ok;
    int t;
    ok = 0;
    t  = 0;
    in_valid = 1'b1;
    in_data  = d[IN_W-1:0];
    in_shift = s[3:0];
    while (!ok && t < 300) begin
      @(negedge clk);
      if (ra) ok = 1;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", ra);
    end
  endtask

  task automatic send_block(input int o0, input int o1, input int o2, input int o3,
                            input int s, input int maxgap);
    int o[4];
    o = '{o0, o1, o2, o3};
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      send(o[k], s);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin @(posedge clk); #1; t++; end
    chk("drain_left", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (va || vb)) begin
      chk("valid_pair", vb, va);
      if (q.size() == 0) begin
        chk("unexpected_out_valid", va, 0);
      end else begin
        chk("a_y1", ya1, q[0].a1); chk("a_y3", ya3, q[0].a3);
        chk("a_y5", ya5, q[0].a5); chk("a_y7", ya7, q[0].a7);
        chk("b_y1", yb1, q[0].b1); chk("b_y3", yb3, q[0].b3);
        chk("b_y5", yb5, q[0].b5); chk("b_y7", yb7, q[0].b7);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    longint h1;
    int o[4];
    int s, t;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", va, 0);
    chk("rst_y1", ya1, 0);
    chk("rst_y7", yb7, 0);
    chk("rst_in_ready", ra, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit impulse, plus latency from the fourth accept.
    out_ready = 1'b1;
    q.push_back(mk(89, 75, 50, 18, 89, 75, 50, 18));
    send_block(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_rnd_valid", va, 0);
    @(negedge clk);
    chk("lat_out_valid", va, 1);
    drain();

    q.push_back(mk(232, -82, 54, -46, 232, -82, 54, -46));
    send_block(1, 1, 1, 1, 0, 2);
    drain();

    q.push_back(mk(22, 19, 13, 5, 22, 19, 13, 5));
    send_block(1, 0, 0, 0, 2, 2);
    drain();

    q.push_back(mk(232000, -82000, 54000, -46000, 32767, -32768, 32767, -32768));
    send_block(1000, 1000, 1000, 1000, 0, 1);
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    q.push_back(model(-3, 7, 100, -250, 1));
    send_block(-3, 7, 100, -250, 1, 0);
    t = 0;
    while (!va && t < 20) begin @(posedge clk); #1; t++; end
    chk("bp_reach_out", va, 1);
    h1 = ya1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_hold", va, 1);
      chk("bp_in_ready", ra, 0);
      chk("bp_y1_stable", ya1, h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_before", ra, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_after", ra, 1);
    chk("bp_valid_drop", va, 0);
    @(posedge clk); #1;
    drain();

    // Abort by clr, which also wins over a simultaneous sample.
    send(5, 3);
    send(-9, 3);
    clr = 1'b1; in_valid = 1'b1; in_data = 19'sd100;
    @(negedge clk);
    chk("clr_in_ready", ra, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    q.push_back(mk(75, -18, -89, -50, 75, -18, -89, -50));
    send_block(0, 1, 0, 0, 0, 1);
    drain();

    // Same abort via reset pulse.
    send(11, 4);
    send(22, 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_y1", ya1, 0);
    chk("rstmid_valid", va, 0);
    chk("rstmid_in_ready", ra, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mk(75, -18, -89, -50, 75, -18, -89, -50));
    send_block(0, 1, 0, 0, 0, 1);
    drain();

    // Random blocks with random gaps and backpressure.
    rdy_rand = 1'b1;
    for (int b = 0; b < 40; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (b % 3 == 0) o[k] = int'($urandom_range(0, 2000)) - 1000;
        else            o[k] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
      end
      s = int'($urandom_range(0, 15));
      q.push_back(model(o[0], o[1], o[2], o[3], s));
      send_block(o[0], o[1], o[2], o[3], s, 3);
    end
    drain();
    rdy_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sau_4o_serial.md
SAU_4O_SERIAL -- requirements
Module: sau_4o_serial

Interface
REQ-001 Parameter IN_W, default 19, signed input sample width.
REQ-002 Parameter OUT_W, default 27, signed output coefficient width; legal range 8..IN_W+9.
REQ-003 Internal accumulator width ACC_W SHALL be IN_W+9, derived and not overridable.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous abort of the block in progress.
REQ-007 in_valid  input  1  in_data/in_shift valid.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  IN_W  signed odd-difference sample o[k]; k = 0..3, serial order.
REQ-010 in_shift  input  4  rounding right-shift, 0..15, meaningful only on the k=0 sample.
REQ-011 out_valid  output  1  y1/y3/y5/y7 valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 y1, y3, y5, y7  output  OUT_W each  signed 8-point DCT-2 odd coefficients.

Function
REQ-014 Results SHALL be, using the same coefficient matrix for forward and inverse use because it is symmetric:
  - y1 = 89o0+75o1+50o2+18o3
  - y3 = 75o0-18o1-89o2-50o3
  - y5 = 50o0-89o1+18o2+75o3
  - y7 = 18o0-50o1+75o2-89o3
REQ-015 Products 18x, 50x, 75x and 89x SHALL be formed with shifts and adds only, with no multiplier operators:
  - 9x = x+8x, 25x = 9x+16x, 18x = 9x<<1, 50x = 25x<<1
  - 75x = (25x<<2)-25x, 89x = 25x+64x
  - all terms sign-extended to ACC_W.
REQ-016 FSM states SHALL be ACC (counter cnt 0..3), RND and OUT.
REQ-017 A sample is accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 only in state ACC.
REQ-018 On accept with cnt=0, the four accumulators SHALL load the signed product term for k=0 (not add to old value), and in_shift SHALL be captured and held for the block.
REQ-019 On accept with cnt=1..2, each accumulator SHALL add its signed term for k=cnt, and cnt SHALL increment.
REQ-020 On accept with cnt=3, the accumulators SHALL add the k=3 term, cnt SHALL wrap to 0, and the FSM SHALL go to RND.
REQ-021 With in_valid=0 in ACC, all state SHALL hold; gaps between samples SHALL be unlimited.
REQ-022 RND lasts exactly 1 cycle; each output register SHALL load round-then-saturate of its accumulator:
  - shift s=0: value unchanged
  - s>0: (acc + 2^(s-1)) >>> s, arithmetic shift
  - then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 The FSM SHALL go RND -> OUT; out_valid SHALL be 1 exactly in OUT, i.e. 2 cycles after the edge accepting the k=3 sample.
REQ-024 In OUT, outputs SHALL hold stable while out_ready=0.
REQ-025 In OUT with out_ready=1, the FSM SHALL go to ACC with cnt=0 next cycle; minimum block period is 6 cycles, with no overlap.
REQ-026 clr=1 in any state SHALL force ACC, cnt=0, out_valid=0 next cycle and discard the partial block; y* values need not change.
REQ-027 clr has priority over any simultaneous in_valid accept or out_ready.
REQ-028 in_ready SHALL be 0 in the cycle clr is sampled high; this is a combinational gating of in_ready by clr.

Reset
REQ-029 While rst_n=0, asynchronously:
  - state=ACC, cnt=0, accumulators=0, captured shift=0
  - y1/y3/y5/y7=0, out_valid=0
  - in_ready=1 when rst_n deasserts.
REQ-030 Reset asserted mid-block or in OUT SHALL discard all data; the first accepted sample after reset SHALL be treated as k=0.

Verification
REQ-031 o=[1,0,0,0], shift 0 -> y1=89, y3=75, y5=50, y7=18; out_valid rises 2 cycles after the 4th accept.
REQ-032 o=[1,1,1,1], shift 0 -> y1=232, y3=-82, y5=54, y7=-46.
REQ-033 o=[1,0,0,0], shift 2 -> y1=22, y3=19, y5=13, y7=5.
REQ-034 OUT_W=16, o=[1000,1000,1000,1000], shift 0 -> y1=32767, y3=-32768, y5=32767, y7=-32768.
REQ-035 out_ready held 0 for 5 cycles in OUT -> outputs and out_valid stable; in_ready=0; the next block accepted only after the out_ready=1 cycle.
REQ-036 clr after 2 samples, then o=[0,1,0,0] -> y1=75, y3=-18, y5=-89, y7=-50, with no residue from the aborted block; repeat with rst_n pulse instead of clr -> same result.
